// File: rtl/wrr_arbiter.sv
// Weighted round-robin / fixed-priority arbiter.
// One grant is held for up to max(weight,1) cycles and re-arbitrates without an idle bubble.
module wrr_arbiter #(
   parameter int NUM_REQUEST  = 4,
   parameter int WEIGHT_WIDTH = 4,
   parameter int IDX_WIDTH    = $clog2(NUM_REQUEST)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                init_in,
   input  logic                                en_in,
   input  logic                                mode_in,
   input  logic [NUM_REQUEST-1:0]              req_in,
   input  logic [NUM_REQUEST*WEIGHT_WIDTH-1:0] weight_in,
   output logic                                granted_out,
   output logic [NUM_REQUEST-1:0]              grant_out,
   output logic [IDX_WIDTH-1:0]                grant_idx_out,
   output logic [WEIGHT_WIDTH-1:0]             credit_out
);

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

   state_t                  r_state, w_state_nxt;
   logic [IDX_WIDTH-1:0]    r_rr_ptr, w_rr_ptr_nxt;
   logic [IDX_WIDTH-1:0]    r_grant_idx, w_grant_idx_nxt;
   logic [WEIGHT_WIDTH-1:0] r_credit, w_credit_nxt;
   logic [NUM_REQUEST-1:0]  r_grant, w_grant_nxt;
   logic                    r_granted, w_granted_nxt;

   logic                    w_arb_start;
   logic                    w_release;
   logic [IDX_WIDTH-1:0]    w_idx_inc;
   logic [IDX_WIDTH-1:0]    w_arb_ptr;
   logic [IDX_WIDTH-1:0]    w_win_idx;
   logic [WEIGHT_WIDTH-1:0] w_win_weight;
   logic [WEIGHT_WIDTH-1:0] w_win_credit;

   // Round-robin searches from ptr with wrap; fixed mode searches from index 0.
   function automatic logic [IDX_WIDTH-1:0] pick_winner(
      input logic [NUM_REQUEST-1:0] req,
      input logic [IDX_WIDTH-1:0]   ptr,
      input logic                   fixed
   );
      logic                 found;
      int                   j;
      logic [IDX_WIDTH-1:0] win;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NUM_REQUEST; k++) begin
         if (fixed) begin
            j = k;
         end else begin
            j = int'(ptr) + k;
            if (j >= NUM_REQUEST) begin
               j = j - NUM_REQUEST;
            end
         end
         if (!found && req[j]) begin
            found = 1'b1;
            win   = IDX_WIDTH'(j);
         end
      end
      return win;
   endfunction

   assign w_idx_inc = (r_grant_idx == IDX_WIDTH'(NUM_REQUEST - 1)) ? '0
                                                                    : r_grant_idx + IDX_WIDTH'(1);

   always_comb begin
      w_state_nxt     = r_state;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_grant_idx_nxt = r_grant_idx;
      w_credit_nxt    = r_credit;
      w_grant_nxt     = r_grant;
      w_granted_nxt   = r_granted;

      w_arb_start = en_in & (|req_in);
      w_release   = (r_state == ST_LOCK) &&
                    (!req_in[r_grant_idx] || (r_credit == WEIGHT_WIDTH'(1)));
      // At a release the search already uses the post-release pointer.
      w_arb_ptr    = (r_state == ST_LOCK) ? w_idx_inc : r_rr_ptr;
      w_win_idx    = pick_winner(req_in, w_arb_ptr, mode_in);
      w_win_weight = weight_in[w_win_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      w_win_credit = (w_win_weight == '0) ? WEIGHT_WIDTH'(1) : w_win_weight;

      case (r_state)
         ST_IDLE: begin
            if (w_arb_start) begin
               w_state_nxt     = ST_LOCK;
               w_granted_nxt   = 1'b1;
               w_grant_idx_nxt = w_win_idx;
               w_grant_nxt     = NUM_REQUEST'(1) << w_win_idx;
               w_credit_nxt    = w_win_credit;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOCK: begin
            if (w_release) begin
               w_rr_ptr_nxt = w_idx_inc;
               if (w_arb_start) begin
                  w_state_nxt     = ST_LOCK;
                  w_granted_nxt   = 1'b1;
                  w_grant_idx_nxt = w_win_idx;
                  w_grant_nxt     = NUM_REQUEST'(1) << w_win_idx;
                  w_credit_nxt    = w_win_credit;
               end else begin
                  w_state_nxt     = ST_IDLE;
                  w_granted_nxt   = 1'b0;
                  w_grant_idx_nxt = '0;
                  w_grant_nxt     = '0;
                  w_credit_nxt    = '0;
               end
            end else if (r_credit != '0) begin
               w_credit_nxt = r_credit - WEIGHT_WIDTH'(1);
            end else begin
               w_credit_nxt = r_credit;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_granted_nxt   = 1'b0;
            w_grant_idx_nxt = '0;
            w_grant_nxt     = '0;
            w_credit_nxt    = '0;
         end
      endcase
   end

   // State and output registers; init_in overrides every other event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_grant_idx <= '0;
         r_credit    <= '0;
         r_grant     <= '0;
         r_granted   <= 1'b0;
      end else if (init_in) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_grant_idx <= '0;
         r_credit    <= '0;
         r_grant     <= '0;
         r_granted   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_grant_idx <= w_grant_idx_nxt;
         r_credit    <= w_credit_nxt;
         r_grant     <= w_grant_nxt;
         r_granted   <= w_granted_nxt;
      end
   end

   assign granted_out   = r_granted;
   assign grant_out     = r_grant;
   assign grant_idx_out = r_grant_idx;
   assign credit_out    = r_credit;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboard bench for wrr_arbiter: a cycle model pushes expected outputs per edge,
// which are popped and compared after the edge; directed scenarios add constant checks.
module tb_wrr_arbiter;

   localparam int N = 4;
   localparam int W = 4;

   typedef struct packed {
      logic         granted;
      logic [N-1:0] grant;
      logic [1:0]   idx;
      logic [W-1:0] credit;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           init_in;
   logic           en_in;
   logic           mode_in;
   logic [N-1:0]   req_in;
   logic [N*W-1:0] weight_in;
   logic           granted_out;
   logic [N-1:0]   grant_out;
   logic [1:0]     grant_idx_out;
   logic [W-1:0]   credit_out;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   // model state
   bit   m_lock;
   int   m_idx;
   int   m_cred;
   int   m_ptr;

   wrr_arbiter #(.NUM_REQUEST(N), .WEIGHT_WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .init_in      (init_in),
      .en_in        (en_in),
      .mode_in      (mode_in),
      .req_in       (req_in),
      .weight_in    (weight_in),
      .granted_out  (granted_out),
      .grant_out    (grant_out),
      .grant_idx_out(grant_idx_out),
      .credit_out   (credit_out)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int m_pick(input bit [N-1:0] req, input int ptr, input bit fixed);
      if (fixed) begin
         for (int i = 0; i < N; i++) if (req[i]) return i;
      end else begin
         for (int c = 0; c < N; c++) if (req[(ptr + c) % N]) return (ptr + c) % N;
      end
      return 0;
   endfunction

   function automatic int m_weight(input bit [N*W-1:0] wv, input int i);
      int v;
      v = int'((wv >> (i * W)) & ((1 << W) - 1));
      return (v == 0) ? 1 : v;
   endfunction

   task automatic m_clear();
      m_lock = 1'b0; m_idx = 0; m_cred = 0; m_ptr = 0;
   endtask

   task automatic set_w(input int w0, input int w1, input int w2, input int w3);
      weight_in = {W'(w3), W'(w2), W'(w1), W'(w0)};
   endtask

   // One clock edge: advance the model on the pre-edge inputs, then compare after the edge.
   task automatic step();
      bit [N-1:0]   s_req;
      bit [N*W-1:0] s_w;
      bit           s_en, s_mode, s_init, start, rel;
      exp_t         e, got;
      s_req = req_in; s_w = weight_in; s_en = en_in; s_mode = mode_in; s_init = init_in;
      @(posedge clk);
      if (s_init) begin
         m_clear();
      end else begin
         start = s_en && (s_req != '0);
         if (!m_lock) begin
            if (start) begin
               m_idx = m_pick(s_req, m_ptr, s_mode); m_lock = 1'b1; m_cred = m_weight(s_w, m_idx);
            end
         end else begin
            rel = !s_req[m_idx] || (m_cred == 1);
            if (rel) begin
               m_ptr = (m_idx + 1) % N;
               if (start) begin
                  m_idx = m_pick(s_req, m_ptr, s_mode); m_cred = m_weight(s_w, m_idx);
               end else begin
                  m_lock = 1'b0; m_idx = 0; m_cred = 0;
               end
            end else begin
               m_cred = m_cred - 1;
            end
         end
      end
      e.granted = m_lock;
      e.grant   = m_lock ? N'(1 << m_idx) : '0;
      e.idx     = 2'(m_idx);
      e.credit  = W'(m_cred);
      sb_q.push_back(e);
      #1;
      got = sb_q.pop_front();
      chk_eq("granted", 32'(granted_out), 32'(got.granted));
      chk_eq("grant", 32'(grant_out), 32'(got.grant));
      chk_eq("grant_idx", 32'(grant_idx_out), 32'(got.idx));
      chk_eq("credit", 32'(credit_out), 32'(got.credit));
   endtask

   task automatic pulse_init();
      init_in = 1'b1;
      step();
      chk_eq("init_granted", 32'(granted_out), 32'd0);
      init_in = 1'b0;
   endtask

   int exp_rr[5]   = '{0, 1, 2, 3, 0};
   int exp_wrr[11] = '{0, 1, 1, 1, 2, 3, 3, 0, 1, 1, 1};

   initial begin
      rst = 1'b1; init_in = 1'b0; en_in = 1'b0; mode_in = 1'b0; req_in = '0; weight_in = '0;
      m_clear();
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_granted", 32'(granted_out), 32'd0);
      chk_eq("rst_grant", 32'(grant_out), 32'd0);
      chk_eq("rst_idx", 32'(grant_idx_out), 32'd0);
      chk_eq("rst_credit", 32'(credit_out), 32'd0);
      rst = 1'b0;

      // fairness, weights 1
      set_w(1, 1, 1, 1); en_in = 1'b1; req_in = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_eq("rr_seq", 32'(grant_idx_out), 32'(exp_rr[i]));
      end
      pulse_init();

      // weighting {1,3,1,2}
      set_w(1, 3, 1, 2); req_in = 4'b1111;
      for (int i = 0; i < 11; i++) begin
         step();
         chk_eq("wrr_seq", 32'(grant_idx_out), 32'(exp_wrr[i]));
      end
      pulse_init();

      // early release of idx2 (weight 5) after two grant cycles
      set_w(1, 1, 5, 2); req_in = 4'b0100;
      step(); chk_eq("early_cred5", 32'(credit_out), 32'd5);
      step(); chk_eq("early_cred4", 32'(credit_out), 32'd4);
      req_in = 4'b1011;
      step(); chk_eq("early_next", 32'(grant_idx_out), 32'd3);
      chk_eq("early_next_cred", 32'(credit_out), 32'd2);
      pulse_init();

      // fixed priority
      mode_in = 1'b1; set_w(1, 1, 1, 1); req_in = 4'b1010;
      for (int i = 0; i < 6; i++) begin
         step();
         chk_eq("fixed_idx", 32'(grant_idx_out), 32'd1);
         chk_eq("fixed_no3", 32'(grant_out[3]), 32'd0);
      end
      mode_in = 1'b0;
      pulse_init();

      // en gating and init mid-grant
      set_w(1, 1, 6, 1); en_in = 1'b0; req_in = 4'b0100;
      step(); step();
      chk_eq("en_gate", 32'(granted_out), 32'd0);
      en_in = 1'b1;
      step(); chk_eq("en_grant", 32'(grant_idx_out), 32'd2);
      step();
      pulse_init();
      chk_eq("init_credit", 32'(credit_out), 32'd0);
      set_w(1, 1, 1, 1); req_in = 4'b1111;
      step(); chk_eq("init_ptr0", 32'(grant_idx_out), 32'd0);
      pulse_init();

      // weight boundaries: 0 -> 1 cycle, all-ones -> 15 cycles
      set_w(0, 15, 1, 1); req_in = 4'b0001;
      step(); chk_eq("w0_cred", 32'(credit_out), 32'd1);
      req_in = 4'b0010;
      step(); chk_eq("w15_cred", 32'(credit_out), 32'd15);
      set_w(3, 3, 3, 3);
      for (int i = 0; i < 14; i++) step();
      chk_eq("w15_last", 32'(credit_out), 32'd1);
      pulse_init();

      // async reset mid-grant
      set_w(1, 9, 1, 1); req_in = 4'b0010;
      step(); step();
      #2;
      rst = 1'b1;
      #1;
      chk_eq("arst_granted", 32'(granted_out), 32'd0);
      chk_eq("arst_grant", 32'(grant_out), 32'd0);
      chk_eq("arst_idx", 32'(grant_idx_out), 32'd0);
      chk_eq("arst_credit", 32'(credit_out), 32'd0);
      m_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_w(1, 1, 1, 1); req_in = 4'b1111;
      step(); chk_eq("arst_first", 32'(grant_idx_out), 32'd0);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         req_in    = N'($urandom_range(0, 15));
         en_in     = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) mode_in = ~mode_in;
         weight_in = (N*W)'($urandom);
         init_in   = ($urandom_range(0, 60) == 0);
         step();
      end
      init_in = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUEST, default 4, number of requesters (legal 2..32).
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 4, bit width of each per-requester weight.
REQ-003 SHALL have parameter IDX_WIDTH, default $clog2(NUM_REQUEST), width of the 0-based grant index.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port init_in  input  1  synchronous soft clear, active-high.
REQ-007 SHALL have port en_in  input  1  permits new arbitration when high.
REQ-008 SHALL have port mode_in  input  1  0 = weighted round-robin, 1 = fixed priority (index 0 highest).
REQ-009 SHALL have port req_in  input  NUM_REQUEST  request vector, bit i = requester i.
REQ-010 SHALL have port weight_in  input  NUM_REQUEST*WEIGHT_WIDTH  packed weights; slice i = [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-011 SHALL have port granted_out  output  1  high while a grant is held.
REQ-012 SHALL have port grant_out  output  NUM_REQUEST  one-hot grant, all zero when not granted.
REQ-013 SHALL have port grant_idx_out  output  IDX_WIDTH  0-based index of holder, 0 when not granted.
REQ-014 SHALL have port credit_out  output  WEIGHT_WIDTH  remaining grant cycles of the holder, 0 when not granted.

Function
REQ-015 SHALL implement two states: IDLE (no grant) and LOCK (one grant held); all outputs driven from registers.
REQ-016 SHALL define arb_start = en_in & |req_in, evaluated in IDLE and at a LOCK release cycle.
REQ-017 SHALL select the winner in round-robin mode as the first set bit of req_in at or after rr_ptr, wrapping from NUM_REQUEST-1 to 0.
REQ-018 SHALL select the winner in fixed mode as the lowest set index of req_in; rr_ptr ignored but still updated.
REQ-019 SHALL, in IDLE on arb_start, enter LOCK next cycle with grant_out one-hot at winner, grant_idx_out = winner, credit = max(weight_in[winner],1); latency req->grant exactly 1 cycle.
REQ-020 SHALL, each LOCK cycle, decrement credit by 1; credit never underflows.
REQ-021 SHALL release the grant when req_in[grant_idx] is low, or when credit == 1 (last owned cycle).
REQ-022 SHALL, on release, set rr_ptr = (grant_idx + 1) mod NUM_REQUEST, non-power-of-2 NUM_REQUEST included.
REQ-023 SHALL, on release with arb_start true, re-arbitrate the same cycle using the updated rr_ptr and stay in LOCK with the new grant (no idle bubble).
REQ-024 SHALL, on release with arb_start false, return to IDLE with all grant outputs zero next cycle.
REQ-025 SHALL keep holding a grant when en_in drops in LOCK; en_in gates only new arbitration.
REQ-026 SHALL allow the releasing requester to win the re-arbitration only if no other requester is active (round-robin) or it is lowest index (fixed).
REQ-027 SHALL sample weight_in only at grant time; later changes do not alter the current credit.
REQ-028 SHALL treat weight 0 as 1 and all-ones as 2^WEIGHT_WIDTH-1 cycles.
REQ-029 SHALL keep a mode_in change during LOCK from affecting the current grant; it applies from the next arbitration.

Reset
REQ-030 SHALL, on rst high, asynchronously force IDLE, rr_ptr = 0, credit = 0, granted_out = 0, grant_out = 0, grant_idx_out = 0, credit_out = 0.
REQ-031 SHALL, on init_in high at a clock edge, apply the same values synchronously, overriding every other event that cycle, including mid-grant.

Verification
REQ-032 SHALL cover round-robin fairness: N=4, weights all 1, req_in=4'b1111 held -> grant_idx 0,1,2,3,0 on consecutive cycles, no bubbles.
REQ-033 SHALL cover weighting: weights {1,3,1,2} (idx 0..3), req_in=4'b1111 held -> idx0 x1, idx1 x3, idx2 x1, idx3 x2 cycles, then repeat.
REQ-034 SHALL cover early release: idx2 granted with weight 5, req_in[2] drops after 2 grant cycles -> grant moves to next active requester the following cycle, rr_ptr = 3.
REQ-035 SHALL cover fixed mode: mode_in=1, weights 1, req_in=4'b1010 held -> grant_idx stays 1 every cycle; idx3 never granted.
REQ-036 SHALL cover en_in gating and init_in: en_in=0 with req_in=4'b0100 -> no grant; en_in=1 -> grant idx2 one cycle later; init_in pulse mid-grant -> all outputs 0 next cycle, rr_ptr 0.
REQ-037 SHALL cover async reset: rst asserted mid-grant between edges -> outputs 0 immediately, then idx0 wins first with req_in=4'b1111 after release.
